// File: rtl/bit_stream_buffer_pkg.sv
// rtl/bit_stream_buffer_pkg.sv - shared constants, types and width helpers for the bit stream buffer
package bit_stream_buffer_pkg;

    localparam int BITS_PER_BYTE = 8;

    typedef logic [BITS_PER_BYTE-1:0] byte_t;

    // Pointer carries one extra MSB beyond the address so full and empty differ.
    function automatic int ptr_width(input int depth_log2);
        return $clog2(2 ** depth_log2) + 1;
    endfunction

    // Unread bit count spans 0..DEPTH*8 inclusive.
    function automatic int avail_width(input int depth_log2);
        return $clog2((2 ** depth_log2) * BITS_PER_BYTE + 1);
    endfunction

endpackage

// File: rtl/bit_stream_buffer_if.sv
// rtl/bit_stream_buffer_if.sv - byte-in / bit-out handshake bundle for the bit stream buffer
// Ports (as signals):
//   byteData/byteValid     byte write from the upstream receiver
//   byteFull               buffer holds DEPTH bytes
//   bitData/bitBufEmpty    show-ahead head bit and its valid (inverted)
//   bitRequest             pop the head bit
//   bitsAvail              unread bit count
//   overflow/underflow     sticky error flags, cleared by clrFlags
// master = producer/consumer side, slave = the buffer.
interface bit_stream_buffer_if
    import bit_stream_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
);
    byte_t                               byteData;
    logic                                byteValid;
    logic                                byteFull;
    logic                                bitData;
    logic                                bitBufEmpty;
    logic                                bitRequest;
    logic [avail_width(DEPTH_LOG2)-1:0]  bitsAvail;
    logic                                overflow;
    logic                                underflow;
    logic                                clrFlags;

    modport master (
        output byteData, byteValid, bitRequest, clrFlags,
        input  byteFull, bitData, bitBufEmpty, bitsAvail, overflow, underflow
    );

    modport slave (
        input  byteData, byteValid, bitRequest, clrFlags,
        output byteFull, bitData, bitBufEmpty, bitsAvail, overflow, underflow
    );

endinterface

// File: rtl/bit_stream_mem.sv
// rtl/bit_stream_mem.sv - DEPTH x 8 register file, one write port, one asynchronous read port
// Ports:
//   clk       clock
//   we_i      write enable
//   waddr_i   write address
//   wdata_i   write byte
//   raddr_i   read address
//   rdata_o   read byte (combinational)
// Contents are not reset; the owner tracks validity with its pointers.
module bit_stream_mem
    import bit_stream_buffer_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  byte_t             wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output byte_t             rdata_o
);

    byte_t mem_q [2 ** ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bit_stream_buffer.sv
// rtl/bit_stream_buffer.sv - byte-in / bit-out show-ahead elastic buffer with overflow/underflow flags
// Ports:
//   clk     system clock
//   reset   asynchronous active-high reset
//   bus     bit_stream_buffer_if.slave: byte write side, bit pop side, status flags
// Parameters:
//   DEPTH_LOG2  log2 of byte storage depth
//   MSB_FIRST   1: bit 7 of each byte is served first; 0: bit 0 first
module bit_stream_buffer
    import bit_stream_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    bit_stream_buffer_if.slave     bus
);

    localparam int PW = ptr_width(DEPTH_LOG2);
    localparam int AW = avail_width(DEPTH_LOG2);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [AW-1:0] bits_avail_q, bits_avail_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          empty;
    logic          full;
    logic          wr_en;
    logic          pop;
    logic [PW-1:0] fill_d;
    logic [2:0]    bit_sel;
    byte_t         rd_byte;

    // Status comes from registered pointers only, so a write while full is
    // dropped even when the same edge retires the head byte.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]) &&
                   (wr_ptr_q[PW-1]   != rd_ptr_q[PW-1]);

    assign wr_en = bus.byteValid  && !full;
    assign pop   = bus.bitRequest && !empty;

    bit_stream_mem #(
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[PW-2:0]),
        .wdata_i (bus.byteData),
        .raddr_i (rd_ptr_q[PW-2:0]),
        .rdata_o (rd_byte)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        bit_idx_d   = bit_idx_q;
        overflow_d  = overflow_q  && !bus.clrFlags;
        underflow_d = underflow_q && !bus.clrFlags;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end

        // A new event in the same cycle as clrFlags keeps the flag set.
        if (bus.byteValid && full) begin
            overflow_d = 1'b1;
        end
        if (bus.bitRequest && empty) begin
            underflow_d = 1'b1;
        end
    end

    // Fill in bytes (mod 2^PW) times 8, less the bits already taken from the head byte.
    assign fill_d       = wr_ptr_d - rd_ptr_d;
    assign bits_avail_d = {fill_d, 3'b000} - {{(AW-3){1'b0}}, bit_idx_d};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            bit_idx_q    <= '0;
            bits_avail_q <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            bit_idx_q    <= bit_idx_d;
            bits_avail_q <= bits_avail_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // 7 - idx is the bitwise inverse of a 3-bit index.
    assign bit_sel = MSB_FIRST ? ~bit_idx_q : bit_idx_q;

    assign bus.bitData     = empty ? 1'b0 : rd_byte[bit_sel];
    assign bus.bitBufEmpty = empty;
    assign bus.byteFull    = full;
    assign bus.bitsAvail   = bits_avail_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_bit_stream_buffer.sv
// tb/tb_bit_stream_buffer.sv - self-checking bench for bit_stream_buffer against a bit-queue model
module tb_bit_stream_buffer;

    localparam int DL        = 4;
    localparam int DEPTH     = 1 << DL;
    localparam int FULL_BITS = (DEPTH - 1) * 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       bit_request = 1'b0;
    logic       clr_flags = 1'b0;

    int total = 0;
    int bad   = 0;

    bit mq [2][$];
    bit m_ovf [2];
    bit m_und [2];

    logic [7:0] g_avail [2];
    logic       g_data  [2];
    logic       g_empty [2];
    logic       g_full  [2];
    logic       g_ovf   [2];
    logic       g_und   [2];

    always #5 clk = ~clk;

    bit_stream_buffer_if #(.DEPTH_LOG2(DL)) bus0 ();
    bit_stream_buffer_if #(.DEPTH_LOG2(DL)) bus1 ();

    assign bus0.byteData   = byte_data;
    assign bus0.byteValid  = byte_valid;
    assign bus0.bitRequest = bit_request;
    assign bus0.clrFlags   = clr_flags;
    assign bus1.byteData   = byte_data;
    assign bus1.byteValid  = byte_valid;
    assign bus1.bitRequest = bit_request;
    assign bus1.clrFlags   = clr_flags;

    assign g_avail[0] = bus0.bitsAvail;   assign g_avail[1] = bus1.bitsAvail;
    assign g_data[0]  = bus0.bitData;     assign g_data[1]  = bus1.bitData;
    assign g_empty[0] = bus0.bitBufEmpty; assign g_empty[1] = bus1.bitBufEmpty;
    assign g_full[0]  = bus0.byteFull;    assign g_full[1]  = bus1.byteFull;
    assign g_ovf[0]   = bus0.overflow;    assign g_ovf[1]   = bus1.overflow;
    assign g_und[0]   = bus0.underflow;   assign g_und[1]   = bus1.underflow;

    bit_stream_buffer #(.DEPTH_LOG2(DL), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    bit_stream_buffer #(.DEPTH_LOG2(DL), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_ovf[k] = 1'b0;
            m_und[k] = 1'b0;
        end
    endfunction

    // One clock edge of the reference: a buffer holds ceil(bits/8) bytes, so it is
    // full once more than (DEPTH-1)*8 bits remain. Decisions use the pre-edge state.
    function automatic void model_step();
        for (int k = 0; k < 2; k++) begin
            int  sz;
            bit  is_full;
            bit  is_empty;
            sz       = mq[k].size();
            is_full  = (sz > FULL_BITS);
            is_empty = (sz == 0);
            if (clr_flags) begin
                m_ovf[k] = 1'b0;
                m_und[k] = 1'b0;
            end
            if (bit_request) begin
                if (is_empty) m_und[k] = 1'b1;
                else void'(mq[k].pop_front());
            end
            if (byte_valid) begin
                if (is_full) begin
                    m_ovf[k] = 1'b1;
                end else begin
                    for (int b = 0; b < 8; b++) begin
                        mq[k].push_back(byte_data[k == 0 ? 7 - b : b]);
                    end
                end
            end
        end
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int sz;
            sz = mq[k].size();
            check($sformatf("avail%0d", k), int'(g_avail[k]), sz);
            check($sformatf("empty%0d", k), int'(g_empty[k]), int'(sz == 0));
            check($sformatf("full%0d", k),  int'(g_full[k]),  int'(sz > FULL_BITS));
            check($sformatf("data%0d", k),  int'(g_data[k]),  sz == 0 ? 0 : int'(mq[k][0]));
            check($sformatf("ovf%0d", k),   int'(g_ovf[k]),   int'(m_ovf[k]));
            check($sformatf("und%0d", k),   int'(g_und[k]),   int'(m_und[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        byte_valid  = 1'b0;
        bit_request = 1'b0;
        clr_flags   = 1'b0;
    endtask

    // Assert reset mid-cycle and check the async clear before any further edge.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        model_clear();
        check("rst_empty", int'(bus0.bitBufEmpty), 1);
        check("rst_avail", int'(bus0.bitsAvail), 0);
        check("rst_data",  int'(bus0.bitData), 0);
        check("rst_full",  int'(bus0.byteFull), 0);
        check("rst_ovf",   int'(bus0.overflow), 0);
        check("rst_und",   int'(bus0.underflow), 0);
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d);
        byte_data  = d;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] rb;

        #1;
        do_reset();

        // 1: 0xA5 popped MSB-first over 8 held-request cycles
        write_byte(8'hA5);
        pat = 8'hA5;
        bit_request = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t1_bit", int'(bus0.bitData), int'(pat[7 - i]));
            tick();
        end
        bit_request = 1'b0;
        check("t1_empty", int'(bus0.bitBufEmpty), 1);

        // 2: fill to capacity, a 17th write is dropped
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
        check("t2_full",  int'(bus0.byteFull), 1);
        check("t2_avail", int'(bus0.bitsAvail), 128);
        write_byte(8'hFF);
        check("t2_ovf",   int'(bus0.overflow), 1);
        check("t2_avail2", int'(bus0.bitsAvail), 128);
        bit_request = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rb = 8'h00;
            for (int b = 0; b < 8; b++) begin
                rb = {rb[6:0], bus0.bitData};
                tick();
            end
            check("t2_byte", int'(rb), i);
        end
        bit_request = 1'b0;
        check("t2_drained", int'(bus0.bitBufEmpty), 1);

        // 3: underflow on empty pop, then clear
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        bit_request = 1'b1;
        tick();
        bit_request = 1'b0;
        check("t3_und",   int'(bus0.underflow), 1);
        check("t3_avail", int'(bus0.bitsAvail), 0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("t3_clr",   int'(bus0.underflow), 0);

        // 4: write while full coincides with the head byte's 8th pop
        for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom));
        bit_request = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        byte_data  = 8'h77;
        byte_valid = 1'b1;
        tick();
        idle_inputs();
        check("t4_ovf",   int'(bus0.overflow), 1);
        check("t4_avail", int'(bus0.bitsAvail), 120);
        check("t4_full",  int'(bus0.byteFull), 0);

        // 5: reset mid-stream discards data, then restart cleanly
        do_reset();
        write_byte(8'hC3);
        write_byte(8'h3C);
        bit_request = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        do_reset();
        write_byte(8'h81);
        check("t5_bit0", int'(bus0.bitData), 1);
        bit_request = 1'b1;
        tick();
        bit_request = 1'b0;
        check("t5_bit1", int'(bus0.bitData), 0);

        // 6: LSB-first instance serves bit 0 first
        do_reset();
        write_byte(8'h01);
        pat = 8'h01;
        bit_request = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t6_bit", int'(bus1.bitData), int'(pat[i]));
            tick();
        end
        bit_request = 1'b0;
        check("t6_empty", int'(bus1.bitBufEmpty), 1);

        // Random soak against the bit-queue model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int phase;
            phase       = (c / 300) % 3;
            byte_data   = 8'($urandom);
            byte_valid  = ($urandom_range(0, 9) < (phase == 0 ? 3 : (phase == 1 ? 1 : 6)));
            bit_request = ($urandom_range(0, 9) < (phase == 2 ? 2 : 7));
            clr_flags   = ($urandom_range(0, 31) == 0);
            tick();
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
